ram_rr_arbiter: RTL and testbench

- Shares one single-port RAM (synchronous write, asynchronous read) between two requesters using round-robin arbitration.
- Each client has a req/gnt handshake; read data is returned registered one cycle after grant.
- Sits between two datapath masters (e.g. a loader and a consumer) and the RAM.
- Contains the RAM core as a sub-module.

---
 rtl/ram_rr_arbiter_pkg.sv | 12 +
 rtl/ram_rr_arbiter_if.sv | 35 +++
 rtl/ram_rr_arbiter_ram_core.sv | 25 ++
 rtl/ram_rr_arbiter.sv | 125 ++++++++++++
 tb/tb_ram_rr_arbiter.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/ram_rr_arbiter_pkg.sv
// ram_arb_pkg: shared constants for the round-robin RAM arbiter.
//   ST_INIT / ST_RUN : controller state encoding
//   CLI0 / CLI1      : client indices, also the encoding of the last-served pointer
package ram_arb_pkg;

  localparam logic ST_INIT = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  localparam logic CLI0 = 1'b0;
  localparam logic CLI1 = 1'b1;

endpackage

// File: rtl/ram_rr_arbiter_if.sv
// ram_rr_arbiter_if: two-client RAM access bus.
//   Per client X in {0,1}:
//     reqX/weX/adrX/dinX : request, write enable, address, write data (client -> arbiter)
//     gntX               : access executes at the next rising edge (arbiter -> client)
//     rvalidX/doutX      : registered read data, one-cycle valid pulse (arbiter -> client)
//   busy : arbiter not accepting requests (init sweep)
//   master modport = client side, slave modport = arbiter side.
interface ram_rr_arbiter_if #(
  parameter int AW = 4,
  parameter int DW = 4
);
  logic          req0, we0;
  logic [AW-1:0] adr0;
  logic [DW-1:0] din0;
  logic          gnt0, rvalid0;
  logic [DW-1:0] dout0;

  logic          req1, we1;
  logic [AW-1:0] adr1;
  logic [DW-1:0] din1;
  logic          gnt1, rvalid1;
  logic [DW-1:0] dout1;

  logic          busy;

  modport master (
    output req0, we0, adr0, din0, req1, we1, adr1, din1,
    input  gnt0, rvalid0, dout0, gnt1, rvalid1, dout1, busy
  );

  modport slave (
    input  req0, we0, adr0, din0, req1, we1, adr1, din1,
    output gnt0, rvalid0, dout0, gnt1, rvalid1, dout1, busy
  );
endinterface

// File: rtl/ram_rr_arbiter_ram_core.sv
// ram_core: single-port RAM, 2**AW x DW.
//   clk    : write clock (rising edge)
//   we_i   : write enable
//   adr_i  : address (shared by read and write)
//   din_i  : write data
//   dout_o : asynchronous read data, mem[adr_i]
module ram_core #(
  parameter int AW = 4,
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] adr_i,
  input  logic [DW-1:0] din_i,
  output logic [DW-1:0] dout_o
);

  logic [DW-1:0] mem_q [2**AW];

  always_ff @(posedge clk)
    if (we_i) mem_q[adr_i] <= din_i;

  assign dout_o = mem_q[adr_i];

endmodule

// File: rtl/ram_rr_arbiter.sv
// ram_rr_arbiter: shares one single-port RAM between two clients with
// round-robin arbitration. One access per cycle; grants are combinational,
// read data is registered and returned one cycle after the grant.
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : ram_rr_arbiter_if.slave (per-client req/we/adr/din, gnt/rvalid/dout, busy)
// Optional feature RAM_RR_ARBITER_CLEAR_EN: after reset an INIT sweep writes 0
// to every RAM word (busy = 1 for 2**AW cycles) before arbitration starts.
// Without it the controller starts directly in RUN and RAM contents are undefined.
module ram_rr_arbiter
  import ram_arb_pkg::*;
#(
  parameter int AW = 4,
  parameter int DW = 4
) (
  input  logic clk,
  input  logic rst,
  ram_rr_arbiter_if.slave bus
);

  logic          state_q;
  logic [AW-1:0] swc_q;
  logic          sweep;

`ifdef RAM_RR_ARBITER_CLEAR_EN
  logic          state_d;
  logic [AW-1:0] swc_d;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= ST_INIT;
      swc_q   <= '0;
    end else begin
      state_q <= state_d;
      swc_q   <= swc_d;
    end

  always_comb begin
    state_d = state_q;
    swc_d   = swc_q;
    if (state_q == ST_INIT) begin
      swc_d = swc_q + 1'b1;
      if (swc_q == {AW{1'b1}}) state_d = ST_RUN;
    end
  end

  always_comb begin
    sweep = (state_q == ST_INIT);
  end
`else
  assign state_q = ST_RUN;
  assign swc_q   = '0;
  assign sweep   = 1'b0;
`endif

  assign bus.busy = sweep;

  // Arbitration: gated by rst so grants drop the instant reset is asserted.
  logic run, gnt0, gnt1, lp_q;

  assign run  = ~rst & (state_q == ST_RUN);
  assign gnt0 = run & bus.req0 & (~bus.req1 | (lp_q == CLI1));
  assign gnt1 = run & bus.req1 & (~bus.req0 | (lp_q == CLI0));

  assign bus.gnt0 = gnt0;
  assign bus.gnt1 = gnt1;

  always_ff @(posedge clk or posedge rst)
    if (rst)       lp_q <= CLI1;
    else if (gnt0) lp_q <= CLI0;
    else if (gnt1) lp_q <= CLI1;

  // RAM port mux: sweep counter has the port during INIT, else the granted client.
  logic          ram_we;
  logic [AW-1:0] ram_adr;
  logic [DW-1:0] ram_din, ram_rdata;

  always_comb begin
    ram_we  = 1'b0;
    ram_adr = bus.adr0;
    ram_din = bus.din0;
    if (sweep) begin
      ram_we  = 1'b1;
      ram_adr = swc_q;
      ram_din = '0;
    end else if (gnt0) begin
      ram_we  = bus.we0;
      ram_adr = bus.adr0;
      ram_din = bus.din0;
    end else if (gnt1) begin
      ram_we  = bus.we1;
      ram_adr = bus.adr1;
      ram_din = bus.din1;
    end
  end

  ram_core #(.AW(AW), .DW(DW)) u_ram (
    .clk   (clk),
    .we_i  (ram_we),
    .adr_i (ram_adr),
    .din_i (ram_din),
    .dout_o(ram_rdata)
  );

  // Read return path; dout holds until the same client's next read.
  logic [1:0]    rvalid_q;
  logic [DW-1:0] dout0_q, dout1_q;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rvalid_q <= '0;
      dout0_q  <= '0;
      dout1_q  <= '0;
    end else begin
      rvalid_q <= {gnt1 & ~bus.we1, gnt0 & ~bus.we0};
      if (gnt0 & ~bus.we0) dout0_q <= ram_rdata;
      if (gnt1 & ~bus.we1) dout1_q <= ram_rdata;
    end

  assign bus.rvalid0 = rvalid_q[0];
  assign bus.rvalid1 = rvalid_q[1];
  assign bus.dout0   = dout0_q;
  assign bus.dout1   = dout1_q;

endmodule

// File: tb/tb_ram_rr_arbiter.sv
// Directed bench for ram_rr_arbiter: expected read data is queued per client
// when a read grant is expected and checked when rvalid returns.
module tb_ram_rr_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram_rr_arbiter_if #(.AW(4), .DW(4)) bus ();
  ram_rr_arbiter #(.AW(4), .DW(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  int vec  = 0;
  int miss = 0;

  logic [3:0] mdl [16];
  logic [3:0] q0 [$];
  logic [3:0] q1 [$];
  logic       pend0 = 1'b0, pend1 = 1'b0;
  logic [3:0] last0 = '0, last1 = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r0, w0, input logic [3:0] a0, d0,
                       input logic r1, w1, input logic [3:0] a1, d1);
    bus.req0 = r0; bus.we0 = w0; bus.adr0 = a0; bus.din0 = d0;
    bus.req1 = r1; bus.we1 = w1; bus.adr1 = a1; bus.din1 = d1;
  endtask

  // Check read return from the previous edge, and that dout holds otherwise.
  task automatic check_rd();
    chk("rvalid0", 32'(bus.rvalid0), 32'(pend0));
    if (pend0 && q0.size() > 0) last0 = q0.pop_front();
    chk("dout0", 32'(bus.dout0), 32'(last0));
    chk("rvalid1", 32'(bus.rvalid1), 32'(pend1));
    if (pend1 && q1.size() > 0) last1 = q1.pop_front();
    chk("dout1", 32'(bus.dout1), 32'(last1));
  endtask

  // One cycle: drive inputs, check the expected grants, update the model.
  task automatic cyc(input logic r0, w0, input logic [3:0] a0, d0,
                     input logic r1, w1, input logic [3:0] a1, d1,
                     input logic e0, e1);
    @(negedge clk);
    check_rd();
    drive(r0, w0, a0, d0, r1, w1, a1, d1);
    #1;
    chk("gnt0", 32'(bus.gnt0), 32'(e0));
    chk("gnt1", 32'(bus.gnt1), 32'(e1));
    pend0 = e0 & ~w0;
    pend1 = e1 & ~w1;
    if (pend0) q0.push_back(mdl[a0]);
    if (pend1) q1.push_back(mdl[a1]);
    if (e0 & w0) mdl[a0] = d0;
    if (e1 & w1) mdl[a1] = d1;
  endtask

  // Assert rst now (both clients requesting), check reset values, release.
  task automatic do_reset();
    rst = 1'b1;
    drive(1'b1, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 4'd0, 4'd0);
    #1;
    chk("rst_gnt0", 32'(bus.gnt0), 0);
    chk("rst_gnt1", 32'(bus.gnt1), 0);
    chk("rst_rvalid0", 32'(bus.rvalid0), 0);
    chk("rst_rvalid1", 32'(bus.rvalid1), 0);
    chk("rst_dout0", 32'(bus.dout0), 0);
    chk("rst_dout1", 32'(bus.dout1), 0);
`ifdef RAM_RR_ARBITER_CLEAR_EN
    chk("rst_busy", 32'(bus.busy), 1);
`else
    chk("rst_busy", 32'(bus.busy), 0);
`endif
    pend0 = 1'b0; pend1 = 1'b0; last0 = '0; last1 = '0;
    q0.delete(); q1.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
`ifdef RAM_RR_ARBITER_CLEAR_EN
    // Client 1 requests during the sweep; it must wait, then be served.
    drive(1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 4'd2, 4'd0);
    for (int m = 0; m < 16; m++) mdl[m] = '0;
    #1;
    chk("busy_init", 32'(bus.busy), 1);
    chk("gnt1_busy", 32'(bus.gnt1), 0);
    for (int i = 1; i < 16; i++) begin
      @(negedge clk); #1;
      chk("busy_init", 32'(bus.busy), 1);
      chk("gnt1_busy", 32'(bus.gnt1), 0);
    end
    @(negedge clk); #1;
    chk("busy_done", 32'(bus.busy), 0);
    chk("gnt1_after_init", 32'(bus.gnt1), 1);
    pend1 = 1'b1;
    q1.push_back(mdl[2]);
`else
    drive(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0);
    #1;
    chk("busy_run", 32'(bus.busy), 0);
`endif
  endtask

  initial begin
    drive(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0);
    @(negedge clk);
    do_reset();

`ifdef RAM_RR_ARBITER_CLEAR_EN
    // Every word reads back 0 after the sweep.
    for (int i = 0; i < 16; i++)
      cyc(1, 0, 4'(i), 0, 0, 0, 0, 0, 1, 0);
`endif

    // Client 0 write then read-back of adr 3.
    cyc(1, 1, 4'd3, 4'hA, 0, 0, 0, 0, 1, 0);
    cyc(1, 0, 4'd3, 4'h0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // From reset, both requesting continuously: grants alternate 0,1,0,1.
    @(negedge clk);
    do_reset();
    cyc(1, 0, 4'd3, 0, 1, 1, 4'd5, 4'h6, 1, 0);
    cyc(1, 0, 4'd3, 0, 1, 1, 4'd5, 4'h6, 0, 1);
    cyc(1, 0, 4'd3, 0, 1, 1, 4'd5, 4'h6, 1, 0);
    cyc(1, 0, 4'd3, 0, 1, 1, 4'd5, 4'h6, 0, 1);
    cyc(0, 0, 0, 0, 1, 0, 4'd5, 0, 0, 1);

    // lp = 0: client 1 writes adr 7 first, client 0 then reads the new data.
    cyc(1, 0, 4'd3, 0, 0, 0, 0, 0, 1, 0);
    cyc(1, 0, 4'd7, 0, 1, 1, 4'd7, 4'h5, 0, 1);
    cyc(1, 0, 4'd7, 0, 0, 0, 0, 0, 1, 0);

    // Top address.
    cyc(1, 1, 4'd15, 4'hF, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0, 4'd15, 0, 0, 1);
    cyc(1, 0, 4'd15, 0, 0, 0, 0, 0, 1, 0);

    // Reset just after a read grant: rvalid/dout drop asynchronously.
    cyc(1, 0, 4'd3, 0, 0, 0, 0, 0, 1, 0);
    @(posedge clk); #2;
    do_reset();
    cyc(1, 0, 4'd3, 0, 0, 0, 0, 0, 1, 0);
    cyc(1, 0, 4'd15, 0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

`ifdef RAM_RR_ARBITER_CLEAR_EN
    // Reset in the middle of a sweep restarts it from 0.
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (9) @(negedge clk);
    #1;
    chk("busy_mid_sweep", 32'(bus.busy), 1);
    do_reset();
    cyc(1, 0, 4'd9, 0, 0, 0, 0, 0, 1, 0);
    cyc(1, 0, 4'd15, 0, 0, 0, 0, 0, 1, 0);
`endif

    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("q0_drained", 32'(q0.size()), 0);
    chk("q1_drained", 32'(q1.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
